// File: rtl/fq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fq_pkg : shared types for the instruction fetch queue
// Revision 1.0 : initial release
// ============================================================================
package fq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fq_fifo : DEPTH-entry FIFO of {pc, inst} entries with synchronous clear
// Revision 1.0 : initial release
// ============================================================================
module fq_fifo
    import fq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fq_entry_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Clear wins over push and pop issued in the same cycle.
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // The fetch FSM never requests more than it can store.
    push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(do_push && full));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_queue : RV32 fetch FSM + PC + instruction FIFO toward decode.
// Optional FQ_STATS_EN adds saturating stall_cycles / flush_count outputs.
// Revision 1.0 : initial release
// ============================================================================
module fetch_queue
    import fq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FQ_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fq_state_e   state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic [31:0] redirect_target;
    logic        outstanding;
    logic [CW-1:0] count;
    logic [CW:0] occupancy;
    logic        full, empty, space;
    logic        push, pop;
    fq_entry_t   head;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign space     = !full && (occupancy < DEPTH_W);

    assign inst_valid = !empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign pop        = inst_valid && inst_ready && !redirect;

    assign imem_req  = (state == REQ);
    assign imem_addr = fetch_pc;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        push          = 1'b0;
        if (redirect) begin
            fetch_pc_next = redirect_target;
            unique case (state)
                IDLE:       state_next = REQ;
                REQ:        state_next = imem_gnt ? DROP : REQ;
                WAIT, DROP: state_next = imem_rvalid ? REQ : DROP;
                default:    state_next = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: if (space) state_next = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        state_next    = WAIT;
                        req_pc_next   = fetch_pc;
                        fetch_pc_next = fetch_pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push = 1'b1;
                        // occupancy already counts this response; a pop frees a slot
                        state_next = (space || pop) ? REQ : IDLE;
                    end
                end
                DROP: if (imem_rvalid) state_next = REQ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            req_pc      <= req_pc_next;
            outstanding <= (state_next == WAIT) || (state_next == DROP);
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

`ifdef FQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (inst_ready && !inst_valid && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue
// Revision 1.0 : initial release
// ============================================================================
module tb_fetch_queue;
    import fq_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FQ_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int compared = 0;
    int mismatched = 0;

    // instruction memory model state
    logic        gnt_en = 1'b0;
    logic        rsp_en = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = '0;
    int          gnt_count = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef FQ_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    // Memory: grants in the request cycle, answers (addr + NOP) when rsp_en allows.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                pending     = 1'b0;
            end else begin
                if (pending && rsp_en) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_addr + RV32_NOP;
                    pending     = 1'b0;
                end else begin
                    imem_rvalid = 1'b0;
                end
                imem_gnt = gnt_en && imem_req && !pending && !imem_rvalid;
                if (imem_gnt) begin
                    pending   = 1'b1;
                    pend_addr = imem_addr;
                    gnt_count++;
                end
            end
        end
    end

    task automatic do_reset(input logic g, input logic r, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        gnt_en = g;
        rsp_en = r;
        inst_ready = rdy;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        inst_ready = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        compared++; if (inst !== 32'h0) begin mismatched++; $display("FAIL rst_inst: got %h expected 0", inst); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL rst_pc: got %h expected 0", inst_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL first_req: got %b expected 1", imem_req); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL early_valid1: got %b expected 0", inst_valid); end
        @(negedge clk);
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL wait_req: got %b expected 0", imem_req); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL early_valid2: got %b expected 0", inst_valid); end
        @(negedge clk);
        compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL first_valid: got %b expected 1", inst_valid); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL first_pc: got %h expected 0", inst_pc); end
        compared++; if (inst !== 32'h13) begin mismatched++; $display("FAIL first_inst: got %h expected 13", inst); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pcs [3];
        int got;
        exp_pcs = '{32'h4, 32'h8, 32'hC};
        got = 0;
        for (int i = 0; i < 30 && got < 3; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                compared++; if (inst_pc !== exp_pcs[got]) begin mismatched++; $display("FAIL stream_pc%0d: got %h expected %h", got, inst_pc, exp_pcs[got]); end
                compared++; if (inst !== exp_pcs[got] + 32'h13) begin mismatched++; $display("FAIL stream_inst%0d: got %h expected %h", got, inst, exp_pcs[got] + 32'h13); end
                got++;
            end
        end
        compared++; if (got != 3) begin mismatched++; $display("FAIL stream_timeout: got %0d entries expected 3", got); end
    endtask

    task automatic test_backpressure;
        int base;
        do_reset(1'b1, 1'b1, 1'b0);
        base = gnt_count;
        repeat (40) @(negedge clk);
        compared++; if (gnt_count - base != 4) begin mismatched++; $display("FAIL bp_grants: got %0d expected 4", gnt_count - base); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL bp_req_low: got %b expected 0", imem_req); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL bp_head: got %h expected 0", inst_pc); end
        @(posedge clk); #1; inst_ready = 1'b1;
        @(posedge clk); #1; inst_ready = 1'b0;
        repeat (30) @(negedge clk);
        compared++; if (gnt_count - base != 5) begin mismatched++; $display("FAIL bp_one_more: got %0d expected 5", gnt_count - base); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL bp_req_low2: got %b expected 0", imem_req); end
        compared++; if (inst_pc !== 32'h4) begin mismatched++; $display("FAIL bp_head2: got %h expected 4", inst_pc); end
    endtask

    task automatic test_redirect_wait;
        int base;
        logic found, seen_req, seen_valid;
        do_reset(1'b1, 1'b0, 1'b1);
        base = gnt_count;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (gnt_count - base == 1) found = 1'b1;
        end
        compared++; if (!found) begin mismatched++; $display("FAIL rw_grant_timeout: got 0 expected 1"); end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk); #1;
        redirect = 1'b0;
        redirect_pc = '0;
        rsp_en = 1'b1;
        @(negedge clk);
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rw_drop_req: got %b expected 0", imem_req); end
        compared++; if (imem_addr !== 32'h100) begin mismatched++; $display("FAIL rw_drop_addr: got %h expected 100", imem_addr); end
        seen_req = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_valid; i++) begin
            @(negedge clk);
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                compared++; if (imem_addr !== 32'h100) begin mismatched++; $display("FAIL rw_addr: got %h expected 100", imem_addr); end
            end
            if (inst_valid) begin
                seen_valid = 1'b1;
                compared++; if (inst_pc !== 32'h100) begin mismatched++; $display("FAIL rw_pc: got %h expected 100", inst_pc); end
                compared++; if (inst !== 32'h113) begin mismatched++; $display("FAIL rw_inst: got %h expected 113", inst); end
            end
        end
        compared++; if (!seen_valid) begin mismatched++; $display("FAIL rw_valid_timeout: got 0 expected 1"); end
    endtask

    task automatic test_redirect_same_cycle;
        int base;
        logic found, seen_valid;
        do_reset(1'b1, 1'b1, 1'b0);
        base = gnt_count;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (gnt_count - base == 3) found = 1'b1;
        end
        compared++; if (!found) begin mismatched++; $display("FAIL rs_grant_timeout: got 0 expected 1"); end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready = 1'b1;
        @(negedge clk);
        compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("FAIL rs_queued: got %b expected 1", inst_valid); end
        @(posedge clk); #1;
        redirect = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rs_flushed: got %b expected 0", inst_valid); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL rs_req: got %b expected 1", imem_req); end
        compared++; if (imem_addr !== 32'h200) begin mismatched++; $display("FAIL rs_addr: got %h expected 200", imem_addr); end
        seen_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_valid; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                seen_valid = 1'b1;
                compared++; if (inst_pc !== 32'h200) begin mismatched++; $display("FAIL rs_pc: got %h expected 200", inst_pc); end
                compared++; if (inst !== 32'h213) begin mismatched++; $display("FAIL rs_inst: got %h expected 213", inst); end
            end
        end
        compared++; if (!seen_valid) begin mismatched++; $display("FAIL rs_valid_timeout: got 0 expected 1"); end
    endtask

    task automatic test_pc_wrap;
        logic seen_low, checked, seen_valid;
        do_reset(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        redirect = 1'b0;
        redirect_pc = '0;
        gnt_en = 1'b1;
        @(negedge clk);
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL wrap_req: got %b expected 1", imem_req); end
        compared++; if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_top: got %h expected fffffffc", imem_addr); end
        seen_low = 1'b0;
        checked = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20 && !(checked && seen_valid); i++) begin
            @(negedge clk);
            if (!imem_req) seen_low = 1'b1;
            else if (seen_low && !checked) begin
                checked = 1'b1;
                compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL wrap_next: got %h expected 0", imem_addr); end
            end
            if (inst_valid && !seen_valid) begin
                seen_valid = 1'b1;
                compared++; if (inst_pc !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_pc: got %h expected fffffffc", inst_pc); end
                compared++; if (inst !== 32'h0000_000F) begin mismatched++; $display("FAIL wrap_inst: got %h expected f", inst); end
            end
        end
        compared++; if (!(checked && seen_valid)) begin mismatched++; $display("FAIL wrap_timeout: got %b%b expected 11", checked, seen_valid); end
    endtask

    task automatic test_reset_in_drop;
        int base;
        logic found;
        do_reset(1'b1, 1'b0, 1'b1);
        base = gnt_count;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (gnt_count - base == 1) found = 1'b1;
        end
        compared++; if (!found) begin mismatched++; $display("FAIL rd_grant_timeout: got 0 expected 1"); end
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0440;
        @(posedge clk); #1;
        redirect = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        compared++; if (imem_addr !== 32'h440) begin mismatched++; $display("FAIL rd_drop_addr: got %h expected 440", imem_addr); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rd_drop_req: got %b expected 0", imem_req); end
`ifdef FQ_STATS_EN
        compared++; if (flush_count !== 16'd1) begin mismatched++; $display("FAIL rd_flush1: got %0d expected 1", flush_count); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rd_req: got %b expected 0", imem_req); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL rd_addr: got %h expected 0", imem_addr); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL rd_valid: got %b expected 0", inst_valid); end
        compared++; if (inst !== 32'h0) begin mismatched++; $display("FAIL rd_inst: got %h expected 0", inst); end
        compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL rd_pc: got %h expected 0", inst_pc); end
`ifdef FQ_STATS_EN
        compared++; if (flush_count !== 16'd0) begin mismatched++; $display("FAIL rd_flush0: got %0d expected 0", flush_count); end
        compared++; if (stall_cycles !== 32'd0) begin mismatched++; $display("FAIL rd_stall0: got %0d expected 0", stall_cycles); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_pc_wrap();
        test_reset_in_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
